// File: rtl/ros_meas_ctrl.sv
// Ring-oscillator measurement sequencer: settles one oscillator, gates a
// window of 2^g clk cycles and counts its synchronized rising edges.
module ros_meas_ctrl #(
   parameter int NUM_RO     = 4,
   parameter int CNT_W      = 16,
   parameter int SETTLE_CYC = 16,
   localparam int SEL_W     = (NUM_RO > 1) ? $clog2(NUM_RO) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              scan,
   input  logic [SEL_W-1:0]  ro_sel,
   input  logic [3:0]        gate_log2,
   input  logic              abort,
   input  logic [NUM_RO-1:0] ro_in,
   output logic [NUM_RO-1:0] ro_ena,
   output logic              busy,
   output logic              done,
   input  logic [SEL_W-1:0]  rd_sel,
   output logic [CNT_W-1:0]  rd_data,
   output logic              rd_ovf
);

   localparam int SET_W = $clog2(SETTLE_CYC + 1);
   localparam int TMR_W = (SET_W > 16) ? SET_W : 16;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      MEASURE,
      DONE
   } state_t;

   state_t state;
   state_t state_nxt;

   logic              scan_q;
   logic [SEL_W-1:0]  chan_q;
   logic [3:0]        g_q;
   logic [TMR_W-1:0]  tmr_q;
   logic [NUM_RO-1:0] sync1_q;
   logic [NUM_RO-1:0] sync2_q;
   logic              hist_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              cnt_ovf_q;
   logic [CNT_W-1:0]  res_q [NUM_RO];
   logic [NUM_RO-1:0] ovf_q;

   logic              cfg_load;
   logic              tmr_clr;
   logic              meas_entry;
   logic              meas_exit;
   logic              chan_inc;
   logic [3:0]        g_eff;
   logic [TMR_W-1:0]  win_last;
   logic [TMR_W-1:0]  set_last;
   logic              sel_sync;
   logic              rise;
   logic              sat;
   logic [CNT_W-1:0]  cnt_nxt;
   logic              ovf_nxt;
   logic              last_ch;

   // Gate windows shorter than 16 cycles are clamped up.
   assign g_eff    = (gate_log2 < 4'd4) ? 4'd4 : gate_log2;
   assign win_last = (TMR_W'(1) << g_q) - TMR_W'(1);
   assign set_last = TMR_W'(SETTLE_CYC - 1);
   assign sel_sync = sync2_q[chan_q];
   assign rise     = sel_sync & ~hist_q;
   assign sat      = &cnt_q;
   assign cnt_nxt  = (rise && !sat) ? cnt_q + CNT_W'(1) : cnt_q;
   assign ovf_nxt  = cnt_ovf_q | (rise & sat);
   assign last_ch  = (chan_q == SEL_W'(NUM_RO - 1));

   always_comb begin
      state_nxt  = state;
      cfg_load   = 1'b0;
      tmr_clr    = 1'b0;
      meas_entry = 1'b0;
      meas_exit  = 1'b0;
      chan_inc   = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nxt = SETTLE;
               cfg_load  = 1'b1;
               tmr_clr   = 1'b1;
            end
         end
         SETTLE: begin
            if (tmr_q == set_last) begin
               state_nxt  = MEASURE;
               tmr_clr    = 1'b1;
               meas_entry = 1'b1;
            end
         end
         MEASURE: begin
            if (tmr_q == win_last) begin
               meas_exit = 1'b1;
               tmr_clr   = 1'b1;
               if (!scan_q || last_ch) begin
                  state_nxt = DONE;
               end else begin
                  state_nxt = SETTLE;
                  chan_inc  = 1'b1;
               end
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
      endcase
      // Abort discards everything in flight, including the result write.
      if (abort) begin
         state_nxt  = IDLE;
         cfg_load   = 1'b0;
         tmr_clr    = 1'b1;
         meas_entry = 1'b0;
         meas_exit  = 1'b0;
         chan_inc   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         scan_q <= 1'b0;
         chan_q <= '0;
         g_q    <= 4'd4;
         tmr_q  <= '0;
      end else begin
         if (cfg_load) begin
            scan_q <= scan;
            g_q    <= g_eff;
            chan_q <= scan ? '0 : ro_sel;
         end else if (chan_inc) begin
            chan_q <= chan_q + SEL_W'(1);
         end
         if (tmr_clr) begin
            tmr_q <= '0;
         end else if (state == SETTLE || state == MEASURE) begin
            tmr_q <= tmr_q + TMR_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= ro_in;
         sync2_q <= sync1_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hist_q    <= 1'b0;
         cnt_q     <= '0;
         cnt_ovf_q <= 1'b0;
      end else if (meas_entry) begin
         hist_q    <= sel_sync;
         cnt_q     <= '0;
         cnt_ovf_q <= 1'b0;
      end else if (state == MEASURE) begin
         hist_q    <= sel_sync;
         cnt_q     <= cnt_nxt;
         cnt_ovf_q <= ovf_nxt;
      end
   end

   // The final window cycle's edge is folded in via cnt_nxt.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_RO; i++) begin
            res_q[i] <= '0;
         end
         ovf_q <= '0;
      end else if (meas_exit) begin
         res_q[chan_q] <= cnt_nxt;
         ovf_q[chan_q] <= ovf_nxt;
      end
   end

   always_comb begin
      ro_ena = '0;
      if (state == SETTLE || state == MEASURE) begin
         ro_ena[chan_q] = 1'b1;
      end
   end

   assign busy    = (state != IDLE);
   assign done    = (state == DONE);
   assign rd_data = res_q[rd_sel];
   assign rd_ovf  = ovf_q[rd_sel];

endmodule

// File: tb/tb_ros_meas_ctrl.sv
// Bench for ros_meas_ctrl: vector table of single runs, scan, saturation,
// abort, busy/start and reset corner cases with a result scoreboard.
module tb_ros_meas_ctrl;

   localparam int NR = 4;
   localparam int CW = 16;
   localparam int SC = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          scan = 1'b0;
   logic          abort = 1'b0;
   logic [1:0]    ro_sel = '0;
   logic [1:0]    rd_sel = '0;
   logic [3:0]    gate_log2 = 4'd4;
   logic [NR-1:0] ro_in = '0;
   logic [NR-1:0] ro_ena;
   logic          busy;
   logic          done;
   logic [CW-1:0] rd_data;
   logic          rd_ovf;

   logic          s_start = 1'b0;
   logic [NR-1:0] s_ro = '0;
   logic [NR-1:0] s_ena;
   logic          s_busy;
   logic          s_done;
   logic [3:0]    s_rd;
   logic          s_ovf;

   ros_meas_ctrl #(.NUM_RO(NR), .CNT_W(CW), .SETTLE_CYC(SC)) dut (
      .clk(clk), .reset(reset), .start(start), .scan(scan),
      .ro_sel(ro_sel), .gate_log2(gate_log2), .abort(abort),
      .ro_in(ro_in), .ro_ena(ro_ena), .busy(busy), .done(done),
      .rd_sel(rd_sel), .rd_data(rd_data), .rd_ovf(rd_ovf)
   );

   ros_meas_ctrl #(.NUM_RO(NR), .CNT_W(4), .SETTLE_CYC(SC)) u_sat (
      .clk(clk), .reset(reset), .start(s_start), .scan(1'b0),
      .ro_sel(2'd0), .gate_log2(4'd8), .abort(1'b0),
      .ro_in(s_ro), .ro_ena(s_ena), .busy(s_busy), .done(s_done),
      .rd_sel(2'd0), .rd_data(s_rd), .rd_ovf(s_ovf)
   );

   int per[NR] = '{0, 0, 0, 0};
   int cyc = 0;

   always @(negedge clk) begin
      cyc++;
      for (int i = 0; i < NR; i++) begin
         ro_in[i] = (per[i] > 0) && ((cyc % per[i]) < per[i] / 2);
      end
      s_ro = {3'b000, ((cyc % 4) < 2)};
   end

   typedef struct {
      int ch;
      int cnt;
      bit ovf;
   } sb_t;

   typedef struct {
      int sel;
      int g;
      int prd;
      int exp;
   } vec_t;

   sb_t  sbq[$];
   int   bank[NR] = '{0, 0, 0, 0};
   bit   bank_ovf[NR] = '{0, 0, 0, 0};
   int   passed = 0;
   int   total = 0;

   task automatic check(input bit ok, input string name,
                        input longint act, input longint exp);
      total++;
      if (ok) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic check_rd(input int ch, input string name);
      int d;
      rd_sel = ch[1:0];
      #1;
      d = int'(rd_data) - bank[ch];
      check(d >= -1 && d <= 1, {name, "_cnt"}, rd_data, bank[ch]);
      check(rd_ovf == bank_ovf[ch], {name, "_ovf"}, rd_ovf, bank_ovf[ch]);
   endtask

   task automatic drain_sb(input string name);
      sb_t e;
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         bank[e.ch] = e.cnt;
         bank_ovf[e.ch] = e.ovf;
         check_rd(e.ch, name);
      end
   endtask

   task automatic launch(input bit sc, input int sel, input int g);
      @(negedge clk);
      start = 1'b1;
      scan = sc;
      ro_sel = sel[1:0];
      gate_log2 = g[3:0];
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int limit, input logic [3:0] ena_exp,
                            output int n, output int ena_cyc);
      n = 0;
      ena_cyc = 0;
      for (int k = 1; k <= limit; k++) begin
         @(negedge clk);
         if (ro_ena == ena_exp) ena_cyc++;
         if (done) begin
            n = k;
            break;
         end
      end
      if (n == 0) check(1'b0, "done_timeout", 0, limit);
   endtask

   vec_t vecs[5];

   initial begin
      int n;
      int ec;
      int geff;
      int bad;
      int ndone;
      logic [3:0] oh;

      vecs[0] = '{2, 6, 8, 8};
      vecs[1] = '{0, 4, 4, 4};
      vecs[2] = '{1, 2, 2, 8};
      vecs[3] = '{3, 7, 16, 8};
      vecs[4] = '{0, 5, 0, 0};

      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check(!busy && !done, "reset_busy_done", {busy, done}, 0);
      check(ro_ena == 0, "reset_ena", ro_ena, 0);
      for (int c = 0; c < NR; c++) check_rd(c, "reset_bank");

      foreach (vecs[i]) begin
         per[vecs[i].sel] = vecs[i].prd;
         geff = (vecs[i].g < 4) ? 4 : vecs[i].g;
         oh = 4'(1 << vecs[i].sel);
         sbq.push_back('{vecs[i].sel, vecs[i].exp, 1'b0});
         launch(1'b0, vecs[i].sel, vecs[i].g);
         wait_done(2000, oh, n, ec);
         check(n == 1 + SC + (1 << geff), "vec_done_time", n, 1 + SC + (1 << geff));
         check(ec == SC + (1 << geff), "vec_ena_cycles", ec, SC + (1 << geff));
         @(negedge clk);
         check(!done && !busy, "vec_done_pulse", {done, busy}, 0);
         drain_sb("vec_result");
      end

      per = '{4, 8, 16, 32};
      sbq.push_back('{0, 4, 1'b0});
      sbq.push_back('{1, 2, 1'b0});
      sbq.push_back('{2, 1, 1'b0});
      sbq.push_back('{3, 0, 1'b0});
      launch(1'b1, 0, 4);
      n = 0;
      for (int k = 1; k <= 400; k++) begin
         @(negedge clk);
         if (k == 1 || k == 33 || k == 65 || k == 97)
            check(ro_ena == 4'(1 << ((k - 1) / 32)), "scan_ena_step",
                  ro_ena, 1 << ((k - 1) / 32));
         if (done) begin
            n = k;
            break;
         end
      end
      check(n == 129, "scan_done_time", n, 129);
      @(negedge clk);
      check(!done && !busy, "scan_done_pulse", {done, busy}, 0);
      drain_sb("scan_result");

      @(negedge clk);
      s_start = 1'b1;
      @(posedge clk);
      #1;
      s_start = 1'b0;
      n = 0;
      for (int k = 1; k <= 600; k++) begin
         @(negedge clk);
         if (s_done) begin
            n = k;
            break;
         end
      end
      check(n == 273, "sat_done_time", n, 273);
      check(s_rd == 4'd15, "sat_result", s_rd, 15);
      check(s_ovf == 1'b1, "sat_ovf", s_ovf, 1);

      per[1] = 4;
      launch(1'b0, 1, 6);
      for (int k = 1; k <= 22; k++) @(negedge clk);
      check(ro_ena == 4'b0010 && busy, "abort_pre_ena", ro_ena, 2);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check(!busy && ro_ena == 0, "abort_idle", {busy, ro_ena}, 0);
      ndone = 0;
      for (int k = 0; k < 120; k++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check(ndone == 0, "abort_no_done", ndone, 0);
      check_rd(1, "abort_bank");

      per[3] = 8;
      sbq.push_back('{3, 2, 1'b0});
      @(negedge clk);
      start = 1'b1;
      scan = 1'b0;
      ro_sel = 2'd3;
      gate_log2 = 4'd4;
      @(posedge clk);
      bad = 0;
      n = 0;
      for (int k = 1; k <= 36; k++) begin
         @(negedge clk);
         if (k == 10) begin
            ro_sel = 2'd0;
            gate_log2 = 4'd8;
            scan = 1'b1;
         end
         if (k <= 32 && ro_ena != 4'b1000) bad++;
         if (done && n == 0) n = k;
         if (k == 34) check(!busy && ro_ena == 0, "b2b_idle_gap", {busy, ro_ena}, 0);
         if (k == 35) begin
            check(busy && ro_ena == 4'b0001, "b2b_retrigger", ro_ena, 1);
            start = 1'b0;
            abort = 1'b1;
         end
         if (k == 36) begin
            abort = 1'b0;
            check(!busy, "b2b_abort", busy, 0);
         end
      end
      check(bad == 0, "busy_cfg_held", bad, 0);
      check(n == 33, "busy_done_time", n, 33);
      drain_sb("busy_result");

      per = '{4, 8, 16, 32};
      launch(1'b1, 0, 2);
      for (int k = 1; k <= 54; k++) begin
         @(negedge clk);
         if (k == 32) check(ro_ena == 4'b0001, "rst_ch0_window_end", ro_ena, 1);
         if (k == 33) check(ro_ena == 4'b0010, "rst_ch1_settle", ro_ena, 2);
         if (k == 50) begin
            check_rd(2, "rd_during_meas2");
            check_rd(3, "rd_during_meas3");
         end
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check(!busy && !done && ro_ena == 0, "rst_mid_idle", {busy, done, ro_ena}, 0);
      for (int c = 0; c < NR; c++) begin
         bank[c] = 0;
         bank_ovf[c] = 1'b0;
         rd_sel = c[1:0];
         #1;
         check(rd_data == 0 && !rd_ovf, "rst_mid_bank", rd_data, 0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/ros_meas_ctrl.md
ROS_MEAS_CTRL -- requirements
Module: ros_meas_ctrl

Interface
REQ-001 SHALL have parameter NUM_RO, default 4, number of ring oscillators sequenced (power of two, 2..8).
REQ-002 SHALL have parameter CNT_W, default 16, width of each edge-count result.
REQ-003 SHALL have parameter SETTLE_CYC, default 16, clk cycles between oscillator enable and gate-window start.
REQ-004 SHALL have port clk  input  1  single system clock; all state on posedge clk.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  level; sampled only in IDLE; begins a measurement.
REQ-007 SHALL have port scan  input  1  sampled with start; 1 = measure all channels 0..NUM_RO-1 in order, 0 = single channel.
REQ-008 SHALL have port ro_sel  input  log2(NUM_RO)  channel for single mode, sampled with start.
REQ-009 SHALL have port gate_log2  input  4  gate window = 2^gate_log2 clk cycles, sampled with start; values below 4 treated as 4.
REQ-010 SHALL have port abort  input  1  terminates any measurement.
REQ-011 SHALL have port ro_in  input  NUM_RO  divided oscillator outputs, asynchronous to clk.
REQ-012 SHALL have port ro_ena  output  NUM_RO  oscillator enables, one-hot or zero.
REQ-013 SHALL have port busy  output  1  high in any state except IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse on completion.
REQ-015 SHALL have port rd_sel  input  log2(NUM_RO)  result-bank read select.
REQ-016 SHALL have port rd_data  output  CNT_W  combinational result[rd_sel].
REQ-017 SHALL have port rd_ovf  output  1  combinational overflow flag of result[rd_sel].

Function
REQ-018 SHALL implement FSM states IDLE, SETTLE, MEASURE, DONE.
REQ-019 IDLE: start=1 and abort=0 -> latch scan, ro_sel, gate_log2; channel = scan ? 0 : ro_sel; go SETTLE.
REQ-020 SETTLE: ro_ena = one-hot(channel); stay exactly SETTLE_CYC cycles, then MEASURE.
REQ-021 MEASURE: ro_ena held; stay exactly 2^g cycles (g = effective gate_log2); count rising edges of channel input.
REQ-022 Each ro_in bit SHALL pass a 2-flop synchronizer; edge = sync=1 and previous sync=0.
REQ-023 Edge-detect history SHALL be loaded with current sync value on MEASURE entry; no edge counted on the entry cycle.
REQ-024 Edge counter SHALL clear on MEASURE entry and saturate at 2^CNT_W-1; any increment attempt at saturation sets overflow.
REQ-025 On MEASURE exit, result[channel] and ovf[channel] SHALL be written; other entries unchanged.
REQ-026 Single mode: MEASURE exit -> DONE; scan mode: channel < NUM_RO-1 -> channel+1, SETTLE; last channel -> DONE.
REQ-027 DONE: done=1, ro_ena=0, one cycle, then IDLE; start still high re-triggers from IDLE next cycle.
REQ-028 ro_ena SHALL be 0 in IDLE and DONE; exactly one bit set in SETTLE/MEASURE.
REQ-029 Timing single mode: start high at edge t -> SETTLE from t+1, MEASURE from t+1+SETTLE_CYC, done high for one cycle at t+1+SETTLE_CYC+2^g.
REQ-030 start while busy SHALL be ignored; latched config unchanged.
REQ-031 abort=1 in any state SHALL force IDLE next cycle, ro_ena=0, no done pulse, no result write; abort has priority over start.
REQ-032 rd_sel changes SHALL reflect on rd_data/rd_ovf in the same cycle, including during measurement.

Reset
REQ-033 reset=1 at posedge SHALL force IDLE, ro_ena=0, busy=0, done=0, all result entries 0, all ovf 0, synchronizers and counters 0.
REQ-034 reset SHALL take priority over abort and start; mid-measurement reset discards partial count.

Verification
REQ-035 Single: ro_sel=2, gate_log2=6, ro_in[2] square wave period 8 clk -> ro_ena=0100 for 16+64 cycles, done at start+81, result[2]=8 (+/-1), ovf[2]=0.
REQ-036 Scan: gate_log2=4, ro_in periods 4/8/16/32 clk -> ro_ena steps 0001,0010,0100,1000, single done after 4*(16+16)+1 cycles, results 4/2/1/0 (+/-1).
REQ-037 Saturation: CNT_W=4, gate_log2=8, period 4 clk -> result=15, ovf=1.
REQ-038 Abort: abort pulsed 5 cycles into MEASURE -> IDLE next cycle, ro_ena=0, done never asserts, result bank unchanged.
REQ-039 Busy/start: start held continuously plus extra start pulses mid-run -> config unchanged; back-to-back runs separated by one IDLE cycle.
REQ-040 Reset mid-scan (channel 1, MEASURE) -> next cycle busy=0, ro_ena=0, all rd_data=0, rd_ovf=0; gate_log2=2 -> window 16 cycles.
